// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side burst controller: state encoding,
// FIFO data width and the default skid depth.
package fifo_pkg;

    localparam int FIFO_DW            = 8;
    localparam int DEFAULT_SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Circular skid buffer that absorbs the FIFO's registered read latency and
// presents its head entry on a valid/ready stream.
module skid_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    // Stream handshake: a word transfers on a clock edge where rd_valid and
    // rd_ready are both high; rd_data is held stable while rd_valid is high
    // and rd_ready is low.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[head_q];
    assign count    = count_q;
    assign pop      = rd_valid && rd_ready;
    // A write into a full buffer is only accepted when the head leaves in the same cycle.
    assign push     = wr_en && ((count_q != CNT_W'(DEPTH)) || pop);

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = wr_data;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller: pops burst_len bytes from a synchronous FIFO and
// streams them out through a skid buffer at up to one byte per clock.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int SKID_DEPTH = DEFAULT_SKID_DEPTH,
    parameter int LEN_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   burst_len,
    output logic               busy,
    output logic               done,
    output logic [LEN_W-1:0]   remaining,
    output logic               fifo_read_enable,
    input  logic               fifo_empty,
    input  logic [FIFO_DW-1:0] fifo_data,
    output logic [FIFO_DW-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output state_t             dbg_state
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] req_cnt_q, req_cnt_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] skid_count;
    logic [OCC_W-1:0] occ_after;
    logic             pop_out;
    logic             can_pop;

    assign pop_out = out_valid && out_ready;
    // Skid slots still claimed after this cycle: stored + in flight - leaving.
    assign occ_after = OCC_W'(skid_count) + OCC_W'(inflight_q) - OCC_W'(pop_out);
    assign can_pop   = !fifo_empty && (req_cnt_q != '0) &&
                       (occ_after < OCC_W'(SKID_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (burst_len != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (fifo_read_enable && (req_cnt_q == LEN_W'(1))) state_d = ST_DRAIN;
            // Leave as the last byte is accepted so done follows it by one cycle.
            ST_DRAIN: if (remaining_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        fifo_read_enable = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy             = 1'b1;
                fifo_read_enable = can_pop;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    always_comb begin
        req_cnt_d   = req_cnt_q;
        remaining_d = remaining_q;
        inflight_d  = fifo_read_enable;
        if ((state_q == ST_IDLE) && start) begin
            req_cnt_d   = burst_len;
            remaining_d = burst_len;
        end else begin
            if (fifo_read_enable) begin
                req_cnt_d = req_cnt_q - LEN_W'(1);
            end
            if (pop_out && (remaining_q != '0)) begin
                remaining_d = remaining_q - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt_q   <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            req_cnt_q   <= req_cnt_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
        end
    end

    skid_buffer #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (FIFO_DW)
    ) u_skid (
        .clk      (clk),
        .rst      (reset),
        .wr_en    (inflight_q),
        .wr_data  (fifo_data),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (skid_count)
    );

    assign remaining = remaining_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO feeds the DUT and every
// burst's output stream is compared with the bytes pushed into that FIFO.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] remaining;
    logic       fifo_read_enable;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] dbg_state;

    fifo_burst_reader #(.SKID_DEPTH(2), .LEN_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .burst_len        (burst_len),
        .busy             (busy),
        .done             (done),
        .remaining        (remaining),
        .fifo_read_enable (fifo_read_enable),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with a one-cycle registered read.
    logic [7:0] fifo_mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_cnt = 0;
    int rd_empty_viol = 0;

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr = wr_ptr;
        end else if (fifo_read_enable) begin
            if (rd_ptr == wr_ptr) begin
                rd_empty_viol++;
            end else begin
                fifo_data <= fifo_mem[rd_ptr % 4096];
                rd_ptr++;
                pop_cnt++;
            end
        end
    end

    always @(negedge clk) fifo_empty = (rd_ptr == wr_ptr);

    // Scoreboard and per-burst observations.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cnt, pop_base, empty_base, max_ahead, stall_viol, busy_drop;
    int done_cnt, done_cycle, last_acc_cycle;
    bit timed_out, in_burst, busy_at_done, prev_valid, prev_ready;
    logic [7:0] prev_data;

    task automatic clear_stats();
        exp_q.delete();
        got_q.delete();
        acc_cnt = 0; pop_base = pop_cnt; empty_base = rd_empty_viol;
        max_ahead = 0; stall_viol = 0; busy_drop = 0; done_cnt = 0;
        done_cycle = -100; last_acc_cycle = -1; timed_out = 0;
        in_burst = 0; prev_valid = 0; prev_ready = 0; busy_at_done = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr % 4096] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    // Observe outputs mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        int ahead;
        @(negedge clk);
        if (in_burst && !busy && !done) busy_drop++;
        if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data)) stall_viol++;
        prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            acc_cnt++;
            last_acc_cycle = cyc;
        end
        ahead = (pop_cnt - pop_base) - acc_cnt;
        if (ahead > max_ahead) max_ahead = ahead;
        if (done) begin
            done_cnt++;
            done_cycle = cyc;
            busy_at_done = busy;
            in_burst = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic kick(input int len);
        start = 1'b1;
        burst_len = 8'(len);
        step();
        start = 1'b0;
        burst_len = 8'($urandom);
        in_burst = (len != 0);
    endtask

    task automatic run_to_done(input int limit, input int pct, input int stall_at,
                               input int stall_len, input int push_at, input int push_n);
        int c = 0;
        while (done_cnt == 0 && c < limit) begin
            out_ready = (int'($urandom_range(99)) < pct);
            if (c >= stall_at && c < stall_at + stall_len) out_ready = 1'b0;
            if (c == push_at) begin
                for (int k = 0; k < push_n; k++) push_byte(8'($urandom));
            end
            step();
            c++;
        end
        timed_out = (done_cnt == 0);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (fifo_read_enable !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fifo_read_enable); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
        n_tests++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [7:0] pat [4];
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        clear_stats();
        for (int i = 0; i < 4; i++) push_byte(pat[i]);
        out_ready = 1'b1;
        step();
        kick(4);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_t1: got %b expected 1", busy); end
        n_tests++; if (fifo_read_enable !== 1'b1) begin n_fail++; $display("FAIL basic_first_pop_t1: got %b expected 1", fifo_read_enable); end
        step();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_t2: got %b expected 0", out_valid); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== pat[i]) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, pat[i]);
            end
        end
        step();
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        n_tests++; if (pop_cnt - pop_base != 4 || rd_ptr != wr_ptr) begin n_fail++; $display("FAIL basic_pops: got %0d pops, left %0d expected 4 pops, left 0", pop_cnt - pop_base, wr_ptr - rd_ptr); end
        step();
        n_tests++; if (done !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL basic_done_pulse: got done=%b state=%0d expected done=0 state=0", done, dbg_state); end
    endtask

    task automatic test_backpressure();
        clear_stats();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        kick(3);
        run_to_done(200, 100, 2, 5, -1, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL bp_timeout: got no done expected done within 200 cycles"); end
        n_tests++; if (stall_viol != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", stall_viol); end
        n_tests++; if (max_ahead > 2) begin n_fail++; $display("FAIL bp_ahead: got %0d bytes popped ahead expected <= 2", max_ahead); end
        n_tests++; if (pop_cnt - pop_base != 3) begin n_fail++; $display("FAIL bp_pops: got %0d expected 3", pop_cnt - pop_base); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_starved();
        clear_stats();
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        kick(5);
        run_to_done(300, 100, -1, 0, 10, 3);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL starve_timeout: got no done expected done within 300 cycles"); end
        n_tests++; if (rd_empty_viol != empty_base) begin n_fail++; $display("FAIL starve_rd_empty: got %0d pops while empty expected 0", rd_empty_viol - empty_base); end
        n_tests++; if (busy_drop != 0) begin n_fail++; $display("FAIL starve_busy: got %0d idle cycles mid-burst expected 0", busy_drop); end
        n_tests++; if (done_cycle != last_acc_cycle + 1 || acc_cnt != 5) begin n_fail++; $display("FAIL starve_done: got done cycle %0d after %0d bytes expected cycle %0d after 5", done_cycle, acc_cnt, last_acc_cycle + 1); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL starve_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL starve_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_and_ignored();
        clear_stats();
        kick(0);
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        step();
        n_tests++; if (done !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL zero_pulse: got done=%b state=%0d expected done=0 state=0", done, dbg_state); end
        n_tests++; if (pop_cnt != pop_base) begin n_fail++; $display("FAIL zero_pops: got %0d expected 0", pop_cnt - pop_base); end
        clear_stats();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        out_ready = 1'b1;
        kick(4);
        step();
        start = 1'b1;
        burst_len = 8'd7;
        step();
        start = 1'b0;
        n_tests++; if (remaining !== 8'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL ignored_start: got remaining=%0d busy=%b expected remaining=4 busy=1", remaining, busy); end
        run_to_done(200, 100, -1, 0, -1, 0);
        n_tests++; if (pop_cnt - pop_base != 4 || remaining !== 8'd0) begin n_fail++; $display("FAIL ignored_pops: got pops=%0d remaining=%0d expected pops=4 remaining=0", pop_cnt - pop_base, remaining); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ignored_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignored_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        out_ready = 1'b0;
        kick(4);
        step();
        step();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got valid=%b expected 1", out_valid); end
        #2 reset = 1'b1;
        in_burst = 0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_immediate: got valid=%b busy=%b expected 0 0", out_valid, busy); end
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        step();
        step();
        n_tests++; if (dbg_state !== 2'd0 || remaining !== 8'd0) begin n_fail++; $display("FAIL rstmid_after: got state=%0d remaining=%0d expected 0 0", dbg_state, remaining); end
        n_tests++; if (out_valid !== 1'b0 || fifo_read_enable !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got valid=%b rd_en=%b expected 0 0", out_valid, fifo_read_enable); end
    endtask

    task automatic test_exact_count();
        clear_stats();
        for (int i = 0; i < 8; i++) push_byte(8'($urandom));
        kick(8);
        run_to_done(400, 50, -1, 0, -1, 0);
        n_tests++; if (timed_out) begin n_fail++; $display("FAIL exact_timeout: got no done expected done within 400 cycles"); end
        n_tests++; if (pop_cnt - pop_base != 8 || rd_ptr != wr_ptr) begin n_fail++; $display("FAIL exact_pops: got %0d pops, left %0d expected 8 pops, left 0", pop_cnt - pop_base, wr_ptr - rd_ptr); end
        n_tests++; if (done_cycle != last_acc_cycle + 1 || busy_at_done !== 1'b0) begin n_fail++; $display("FAIL exact_done: got cycle %0d busy=%b expected cycle %0d busy=0", done_cycle, busy_at_done, last_acc_cycle + 1); end
        n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL exact_count: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL exact_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len, pre;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(12, 1);
            pre = $urandom_range(len, 0);
            clear_stats();
            for (int i = 0; i < pre; i++) push_byte(8'($urandom));
            kick(len);
            run_to_done(500, $urandom_range(100, 30), -1, 0, $urandom_range(15, 0), len - pre);
            n_tests++; if (timed_out) begin n_fail++; $display("FAIL rand%0d_timeout: got no done expected done within 500 cycles", it); end
            n_tests++; if (pop_cnt - pop_base != len || remaining !== 8'd0) begin n_fail++; $display("FAIL rand%0d_pops: got pops=%0d remaining=%0d expected pops=%0d remaining=0", it, pop_cnt - pop_base, remaining, len); end
            n_tests++; if (done_cycle != last_acc_cycle + 1 || done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: got cycle %0d count %0d expected cycle %0d count 1", it, done_cycle, done_cnt, last_acc_cycle + 1); end
            n_tests++; if (max_ahead > 2 || stall_viol != 0) begin n_fail++; $display("FAIL rand%0d_flow: got ahead=%0d stall_changes=%0d expected <=2 and 0", it, max_ahead, stall_viol); end
            n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d bytes expected %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h expected %h", it, i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_starved();
        test_zero_and_ignored();
        test_reset_mid();
        test_exact_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
